// File: rtl/pipe_arb.sv
// Round-robin arbiter/sequencer sharing one fixed-latency arithmetic pipe among N requesters.
// Optional build macro PIPE_ARB_PRIO_EN gives requester 0 strict priority over the round-robin set.
module pipe_arb #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_x,
  input  logic [N*W-1:0]       req_y,
  output logic [N-1:0]         req_ready,
  input  logic                 hold,
  output logic [W-1:0]         pipe_x,
  output logic [W-1:0]         pipe_y,
  input  logic [2*W+1:0]       pipe_s2,
  input  logic [2*W-1:0]       pipe_out,
  output logic [N-1:0]         rsp_valid,
  output logic [2*W+1:0]       rsp_s2,
  output logic [2*W-1:0]       rsp_out,
  output logic                 idle
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_RUN, ST_HOLD} state_e;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  tag_t [LAT:0]      tag_q, tag_d;
  logic [W-1:0]      pipe_x_q, pipe_x_d, pipe_y_q, pipe_y_d;
  logic [N-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*W+1:0]    rsp_s2_q, rsp_s2_d;
  logic [2*W-1:0]    rsp_out_q, rsp_out_d;

  logic              issue_en;
  logic              win_found;
  logic [IW-1:0]     win_id;
  logic              grant;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  state_d = hold ? ST_HOLD : ST_RUN;
      ST_HOLD: state_d = hold ? ST_HOLD : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs; hold blocks grants in the very cycle it is raised
  always_comb begin
    issue_en = (state_q == ST_RUN) && !hold && !rst;
  end

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin : arb
    int idx;
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
`ifdef PIPE_ARB_PRIO_EN
    if (req_valid[0]) win_found = 1'b1;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
`ifdef PIPE_ARB_PRIO_EN
      if (!win_found && idx != 0 && req_valid[idx]) begin
`else
      if (!win_found && req_valid[idx]) begin
`endif
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  always_comb begin
    grant     = issue_en && win_found;
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;

    ptr_d = ptr_q;
`ifdef PIPE_ARB_PRIO_EN
    if (grant && win_id != '0)
`else
    if (grant)
`endif
      ptr_d = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;

    pipe_x_d = pipe_x_q;
    pipe_y_d = pipe_y_q;
    if (grant) begin
      pipe_x_d = req_x[int'(win_id)*W +: W];
      pipe_y_d = req_y[int'(win_id)*W +: W];
    end

    // Tags shift every cycle: the pipe never stalls.
    tag_d[0].valid = grant;
    tag_d[0].id    = win_id;
    for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];

    rsp_valid_d = '0;
    rsp_s2_d    = rsp_s2_q;
    rsp_out_d   = rsp_out_q;
    if (tag_q[LAT].valid) begin
      rsp_valid_d[tag_q[LAT].id] = 1'b1;
      rsp_s2_d                   = pipe_s2;
      rsp_out_d                  = pipe_out;
    end
  end

  always_comb begin
    logic busy;
    busy = 1'b0;
    for (int i = 0; i <= LAT; i++) busy = busy | tag_q[i].valid;
    idle = !busy && !grant;
  end

  // Tags are flops, not a memory, so clearing them on reset is cheap and drops in-flight ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      ptr_q       <= '0;
      tag_q       <= '0;
      pipe_x_q    <= '0;
      pipe_y_q    <= '0;
      rsp_valid_q <= '0;
      rsp_s2_q    <= '0;
      rsp_out_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_q       <= tag_d;
      pipe_x_q    <= pipe_x_d;
      pipe_y_q    <= pipe_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_s2_q    <= rsp_s2_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  assign pipe_x    = pipe_x_q;
  assign pipe_y    = pipe_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s2    = rsp_s2_q;
  assign rsp_out   = rsp_out_q;

endmodule

// File: tb/tb_pipe_arb.sv
// Bench for pipe_arb: stand-in arithmetic pipe, queue-based reference model, table vectors and corner sequences.
module tb_pipe_arb;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_x = '0;
  logic [N*W-1:0]   req_y = '0;
  logic [N-1:0]     req_ready;
  logic             hold = 1'b0;
  logic [W-1:0]     pipe_x, pipe_y;
  logic [2*W+1:0]   pipe_s2;
  logic [2*W-1:0]   pipe_out;
  logic [N-1:0]     rsp_valid;
  logic [2*W+1:0]   rsp_s2;
  logic [2*W-1:0]   rsp_out;
  logic             idle;

  pipe_arb #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .hold(hold), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_s2(pipe_s2), .pipe_out(pipe_out), .rsp_valid(rsp_valid),
    .rsp_s2(rsp_s2), .rsp_out(rsp_out), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic longint f_s2(longint x, longint y);
    return (x + y) * (x + y);
  endfunction

  function automatic longint f_out(longint x);
    longint m;
    m = longint'(1) << (2 * W);
    return (x * x + m - 1) % m;
  endfunction

  // Stand-in for the shared arithmetic pipe: LAT register stages.
  logic [2*W+1:0] s2_p [LAT] = '{default: '0};
  logic [2*W-1:0] out_p[LAT] = '{default: '0};
  always @(posedge clk) begin
    s2_p[0]  <= (2*W+2)'(f_s2(longint'(pipe_x), longint'(pipe_y)));
    out_p[0] <= (2*W)'(f_out(longint'(pipe_x)));
    for (int i = 1; i < LAT; i++) begin
      s2_p[i]  <= s2_p[i-1];
      out_p[i] <= out_p[i-1];
    end
  end
  assign pipe_s2  = s2_p[LAT-1];
  assign pipe_out = out_p[LAT-1];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending responses with the cycle they are due.
  typedef struct {
    int     due;
    int     id;
    longint s2;
    longint out;
  } pend_t;

  pend_t  pend[$];
  int     m_ptr = 0;
  bit     m_hold = 0;
  int     cyc = 0;
  longint last_s2 = 0, last_out = 0, exp_px = 0, exp_py = 0;

  function automatic int model_pick(input logic [N-1:0] v);
`ifdef PIPE_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
`ifdef PIPE_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ptr = 0; m_hold = 0;
    last_s2 = 0; last_out = 0; exp_px = 0; exp_py = 0;
  endtask

  // Check one cycle's outputs against the model, advance the model, move to the next negedge.
  task automatic step();
    int pick;
    bit g;
    longint exp_ready, exp_rv, x, y;
    #1;
    pick = model_pick(req_valid);
    g = !m_hold && !hold && (pick >= 0);
    exp_ready = g ? (longint'(1) << pick) : 0;
    exp_rv = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv   = longint'(1) << pend[0].id;
      last_s2  = pend[0].s2;
      last_out = pend[0].out;
      void'(pend.pop_front());
    end
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_s2", rsp_s2, last_s2);
    check("rsp_out", rsp_out, last_out);
    check("pipe_x", pipe_x, exp_px);
    check("pipe_y", pipe_y, exp_py);
    check("idle", idle, (pend.size() == 0 && !g) ? 1 : 0);
    if (g) begin
      x = longint'(req_x[pick*W +: W]);
      y = longint'(req_y[pick*W +: W]);
      pend.push_back('{due: cyc + LAT + 2, id: pick, s2: f_s2(x, y), out: f_out(x)});
      exp_px = x; exp_py = y;
`ifdef PIPE_ARB_PRIO_EN
      if (pick != 0) m_ptr = (pick + 1) % N;
`else
      m_ptr = (pick + 1) % N;
`endif
    end
    m_hold = hold;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    hold = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst req_ready", req_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_s2", rsp_s2, 0);
    check("rst rsp_out", rsp_out, 0);
    check("rst pipe_x", pipe_x, 0);
    check("rst pipe_y", pipe_y, 0);
    check("rst idle", idle, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*W +: W] = W'(x);
    req_y[i*W +: W] = W'(y);
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    int     id;
    int     x;
    int     y;
    longint s2;
    longint out;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    logic [N-1:0] seen;

    tbl[0] = '{id: 1, x: 3,   y: 4,   s2: 49,     out: 8};
    tbl[1] = '{id: 2, x: 255, y: 255, s2: 260100, out: 65024};
    tbl[2] = '{id: 3, x: 0,   y: 0,   s2: 0,      out: 65535};
    tbl[3] = '{id: 0, x: 7,   y: 2,   s2: 81,     out: 48};
    tbl[4] = '{id: 1, x: 1,   y: 0,   s2: 1,      out: 0};

    do_reset();

    // Single ops: grant same cycle, response five cycles later with constant expectations.
    foreach (tbl[k]) begin
      set_op(tbl[k].id, tbl[k].x, tbl[k].y);
      req_valid = '0;
      req_valid[tbl[k].id] = 1'b1;
      #1;
      check("tbl grant", req_ready, longint'(1) << tbl[k].id);
      step();
      req_valid = '0;
      n = 1;
      while (rsp_valid == '0 && n < 12) begin
        step();
        n++;
      end
      check("tbl latency", n, LAT + 2);
      check("tbl rsp_valid", rsp_valid, longint'(1) << tbl[k].id);
      check("tbl rsp_s2", rsp_s2, tbl[k].s2);
      check("tbl rsp_out", rsp_out, tbl[k].out);
      step();
    end

    // Fairness: all valid right after reset.
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
`ifndef PIPE_ARB_PRIO_EN
      #1;
      check("fair order", req_ready, longint'(1) << (k % N));
`endif
      step();
    end
    drain(8);

    // Hold/drain: three back-to-back grants, then hold with requests still pending.
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 3; k++) step();
    hold = 1'b1;
    seen = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      seen = seen | req_ready;
      step();
    end
    check("hold no grant", seen, 0);
    check("hold idle", idle, 1);
    hold = 1'b0;
    step();
    #1;
`ifdef PIPE_ARB_PRIO_EN
    check("resume grant", req_ready, 1);
`else
    check("resume grant", req_ready, 8);
`endif
    step();
    drain(8);

    // Reset mid-flight: two ops in flight are dropped.
    do_reset();
    req_valid = 4'b0011;
    step();
    step();
    drain(2);
    do_reset();
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      seen = seen | rsp_valid;
      step();
    end
    check("rst flight rsp", seen, 0);
    check("rst flight idle", idle, 1);

`ifdef PIPE_ARB_PRIO_EN
    do_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("prio req0", req_ready, 1);
      step();
    end
    req_valid = 4'b0100;
    #1;
    check("prio req2", req_ready, 4);
    step();
    drain(8);
`endif

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      req_x = (N*W)'({$urandom, $urandom});
      req_y = (N*W)'({$urandom, $urandom});
      hold = ($urandom_range(0, 9) == 0);
      step();
    end
    hold = 1'b0;
    drain(10);
    check("final idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_arb.md
Name: pipe_arb

Overview:
- Round-robin arbiter and sequencer that shares one instance of the 3-stage arithmetic pipe (s2 = (x+y)^2, out = x^2-1) among N requesters.
- Accepts one operand pair per cycle via valid/ready and drives the pipe's x/y inputs from a registered issue stage.
- Tracks in-flight requester IDs in a tag shift register and routes each pipe result back to its requester with a valid pulse.
- Provides a hold/drain control so software can quiesce the pipe before reconfiguration.

Parameters:
- W, 8, operand width; must match the pipe's W.
- N, 4, number of requesters (2..16).
- LAT, 3, pipe latency in cycles from x/y to s2/out valid.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  N  per-requester operand valid.
- req_x  input  N*W  operands x; requester i uses bits [i*W +: W].
- req_y  input  N*W  operands y; same packing as req_x.
- req_ready  output  N  one-hot or zero; requester i's beat is accepted when req_valid[i] & req_ready[i].
- hold  input  1  stop issuing new operations; drain the pipe.
- pipe_x  output  W  to pipe x (registered).
- pipe_y  output  W  to pipe y (registered).
- pipe_s2  input  2*W+2  from pipe s2.
- pipe_out  input  2*W  from pipe out.
- rsp_valid  output  N  one-hot result strobe, 1 cycle.
- rsp_s2  output  2*W+2  result s2 (registered).
- rsp_out  output  2*W  result out (registered).
- idle  output  1  high when no operation is in flight and state is HOLD or nothing is issuing.

Behaviour:
- Reset values: req_ready=0, pipe_x=0, pipe_y=0, rsp_valid=0, rsp_s2=0, rsp_out=0, idle=1; rr pointer=0; tag valid bits all 0; state=RUN.
- FSM states:
  - RUN: req_ready is asserted combinationally to the round-robin winner among req_valid.
  - HOLD: req_ready=0.
  - RUN->HOLD when hold=1; takes effect the same cycle, so no grant is made in the cycle hold is high.
  - HOLD->RUN when hold=0 (the following cycle may grant).
- Arbitration:
  - Search starts at the rr pointer and walks upward with wrap N-1 -> 0; the first requester with req_valid wins.
  - After a grant to i, the pointer becomes (i+1) mod N.
  - The pointer does not move when there is no grant.
  - At most one grant per cycle.
- Issue: on a grant at cycle t, pipe_x/pipe_y <= winner's operands at t+1. With no grant, pipe_x/pipe_y hold their previous values (no toggling); the tag marks the slot invalid.
- Tag pipe:
  - LAT+1 entries of {valid, id[clog2(N)-1:0]}.
  - Entry 0 is loaded at the grant clock edge and shifts every cycle unconditionally, since the pipe has no stall.
  - Once the tag reaches the end, pipe_s2/pipe_out correspond to that operand.
- Response:
  - pipe outputs are captured into rsp_s2/rsp_out.
  - rsp_valid[id] pulses at cycle t+LAT+2 relative to the grant cycle t: latency 5 for LAT=3.
  - rsp_s2/rsp_out hold their last value when there is no response.
  - There is no response backpressure; requesters must always accept.
- idle = no tag valid bit set and no grant in the current cycle.
- Arithmetic: no width conversion in this block. s2 max (2^W-1)*2 squared fits in 2W+2 bits; out wraps modulo 2^(2W) (x=0 -> 2^(2W)-1).
- Boundaries:
  - Back-to-back grants to the same requester are allowed when it is the only one valid.
  - hold asserted while ops are in flight: those ops still complete and respond; idle rises once the last response has issued.
  - rst mid-operation: in-flight tags are discarded and no responses are produced for them.
  - req_valid deasserted by a requester before its grant: that request is not accepted; no penalty.

Optional Feature:
- PIPE_ARB_PRIO_EN defined:
  - Requester 0 has strict priority; whenever req_valid[0]=1 it wins regardless of the rr pointer.
  - Round-robin applies among 1..N-1 only, and the pointer is not advanced by requester-0 grants.
- Undefined: pure round-robin over all N as above.

Test Plan:
- Single op: req_valid=0010, req_x[1]=3, req_y[1]=4 at cycle 0 -> req_ready=0010 at cycle 0; rsp_valid=0010 at cycle 5 with rsp_s2=49, rsp_out=8.
- Fairness: all four req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, 1 per cycle, each with its own operands' results.
- Wrap/limits (W=8):
  - x=255, y=255 -> rsp_s2=260100, rsp_out=65024.
  - x=0, y=0 -> rsp_s2=0, rsp_out=65535.
- Hold/drain: issue 3 back-to-back ops, assert hold the next cycle -> no further req_ready; 3 responses arrive; idle=1 on the cycle after the last rsp_valid; deassert hold -> grants resume from the saved pointer.
- Reset mid-flight: grant 2 ops, pulse rst 2 cycles later -> rsp_valid stays 0 for the following 10 cycles, all outputs are at reset values, idle=1.
- PIPE_ARB_PRIO_EN: req 0 and req 2 valid continuously -> req 0 is granted every cycle; drop req 0 -> req 2 is granted the next cycle.
